// File: rtl/rf_pkg.sv
// rf_pkg: shared constants, the write-back entry type and a pointer-width helper
//   for the register-file write-back arbiter.
package rf_pkg;
    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    // One extra MSB distinguishes full from empty when the index bits match.
    function automatic int ptr_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry synchronous FIFO holding write-back entries.
//   clk, reset (async active-low), flush (sync clear)
//   push/wdata : write side, ignored when full or flushing
//   pop/rdata  : read side, rdata shows the head entry, pop ignored when empty
//   full/empty : status decoded from the registered pointers only
module wb_fifo
    import rf_pkg::*;
#(
    parameter int W     = AW + XLEN,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PW = ptr_bits(DEPTH);

    logic [PW-1:0] wp, rp;
    logic [W-1:0]  mem [DEPTH];
    logic          do_push, do_pop;

    assign empty   = wp == rp;
    assign full    = (wp[PW-1] != rp[PW-1]) && (wp[PW-2:0] == rp[PW-2:0]);
    assign rdata   = mem[rp[PW-2:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + PW'(1);
            if (do_pop)  rp <= rp + PW'(1);
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[PW-2:0]] <= wdata;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between ALU and LSU
//   write-back sources through per-source FIFOs and a round-robin arbiter.
//   clk, reset (async active-low), flush (sync clear of FIFOs and write port)
//   alu_valid/alu_ready/alu_rd/alu_data : ALU result push interface
//   lsu_valid/lsu_ready/lsu_rd/lsu_data : LSU result push interface
//   reg_write/rd/write_data             : registered register-file write port
//   busy      : any FIFO non-empty or a write in flight
//   stall_cnt : saturating backpressure cycle count, only when WB_STALL_CNT_EN
//               is defined; otherwise constant zero
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int XLEN  = rf_pkg::XLEN,
    parameter int AW    = rf_pkg::AW,
    parameter int DEPTH = rf_pkg::DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            reg_write,
    output logic [AW-1:0]   rd,
    output logic [XLEN-1:0] write_data,
    output logic            busy,
    output logic [15:0]     stall_cnt
);
    localparam int W = AW + XLEN;

    typedef enum logic {PRI_ALU, PRI_LSU} pri_t;

    pri_t          prio;
    logic          a_full, a_empty, l_full, l_empty;
    logic [W-1:0]  a_head, l_head, sel;
    logic          pick_lsu, grant, contend;
    logic [AW-1:0] sel_rd;

    assign alu_ready = !a_full;
    assign lsu_ready = !l_full;
    assign contend   = !a_empty && !l_empty;
    assign pick_lsu  = !l_empty && (a_empty || prio == PRI_LSU);
    assign grant     = !flush && (!a_empty || !l_empty);
    assign sel       = pick_lsu ? l_head : a_head;
    assign sel_rd    = sel[W-1 -: AW];
    assign busy      = !a_empty || !l_empty || reg_write;

    wb_fifo #(.W(W), .DEPTH(DEPTH)) u_alu_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (alu_valid),
        .wdata ({alu_rd, alu_data}),
        .pop   (grant && !pick_lsu),
        .rdata (a_head),
        .full  (a_full),
        .empty (a_empty)
    );

    wb_fifo #(.W(W), .DEPTH(DEPTH)) u_lsu_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (lsu_valid),
        .wdata ({lsu_rd, lsu_data}),
        .pop   (grant && pick_lsu),
        .rdata (l_head),
        .full  (l_full),
        .empty (l_empty)
    );

    // Priority only rotates when both sources compete; a lone source never
    // steals the other's turn.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio       <= PRI_ALU;
            reg_write  <= 1'b0;
            rd         <= '0;
            write_data <= '0;
        end else if (flush) begin
            prio      <= PRI_ALU;
            reg_write <= 1'b0;
        end else begin
            reg_write <= grant && (sel_rd != '0);
            if (grant) begin
                rd         <= sel_rd;
                write_data <= sel[XLEN-1:0];
                if (contend) prio <= (prio == PRI_ALU) ? PRI_LSU : PRI_ALU;
            end
        end
    end

`ifdef WB_STALL_CNT_EN
    logic stall;
    assign stall = (alu_valid && !alu_ready) || (lsu_valid && !lsu_ready);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_cnt <= '0;
        else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`else
    assign stall_cnt = 16'h0;
`endif
endmodule
